// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer that sits directly behind the UART receiver.
//   Each byte is captured on the receiver's one-cycle done tick and stored in
//   a circular FIFO. Bytes are presented first-word-fall-through: dout always
//   shows the head entry, and a pop on rd advances to the next one.
//
// Ports
//   clk          single clock, all state changes on posedge
//   reset        synchronous, active-high; wins over every other input
//   wr_tick      write strobe (receiver rx_done_tick); one write per high cycle
//   din          byte captured when wr_tick=1
//   rd           pop request; head consumed on the edge where rd=1
//   dout         head word, valid whenever empty=0
//   empty/full   decoded from the registered level
//   level        number of stored words, 0..2**ADDR_W
//   overflow     sticky, set when a write is dropped because the FIFO is full
//   ovf_clr      clears overflow; a drop in the same cycle takes priority
//   almost_full  (only with RX_FIFO_ALMOST_FULL_EN) level >= AF_LVL
//
// Configuration macro: RX_FIFO_ALMOST_FULL_EN adds the almost_full output.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_tick,
    input  logic [DBIT-1:0]   din,
    input  logic              rd,
    output logic [DBIT-1:0]   dout,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
`ifdef RX_FIFO_ALMOST_FULL_EN
    output logic              almost_full,
`endif
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int            DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DBIT-1:0]   mem_reg [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   level_reg;
    logic [ADDR_W:0]   level_next;
    logic              overflow_reg;

    logic              wr_ok;
    logic              rd_ok;
    logic              drop;
    logic [DEPTH-1:0]  wr_sel;

    // Flags come only from the registered level, never from rd/wr_tick.
    assign empty = (level_reg == '0);
    assign full  = (level_reg == DEPTH_L);
    assign level = level_reg;
    assign overflow = overflow_reg;

    // A write into a full FIFO still lands when a pop frees the head slot in
    // the same edge; a pop on an empty FIFO is simply ignored.
    assign wr_ok = wr_tick && (!full || rd);
    assign rd_ok = rd && !empty;
    assign drop  = wr_tick && full && !rd;

    // One-hot write select per storage entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_ok && (wr_ptr_reg == ADDR_W'(gi));
        end
    endgenerate

    // Entries are cleared on reset so dout reads 0 until the first write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                mem_reg[i] <= '0;
            end else if (wr_sel[i]) begin
                mem_reg[i] <= din;
            end
        end
    end

    // Combinational FWFT read straight from the storage array.
    assign dout = mem_reg[rd_ptr_reg];

    always_comb begin
        level_next = level_reg;
        case ({wr_ok, rd_ok})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

`ifdef RX_FIFO_ALMOST_FULL_EN
    assign almost_full = (level_reg >= (ADDR_W + 1)'(AF_LVL));
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo. Directed scenarios followed by a
//   randomized run, all checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_tick = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd = 1'b0;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overflow;
    logic       ovf_clr = 1'b0;
`ifdef RX_FIFO_ALMOST_FULL_EN
    logic       almost_full;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: contents as a queue, plus the sticky overflow bit.
    logic [7:0] q_m[$];
    logic       ovf_m = 1'b0;

    uart_rx_fifo #(.DBIT(8), .ADDR_W(4), .AF_LVL(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_tick    (wr_tick),
        .din        (din),
        .rd         (rd),
        .dout       (dout),
        .empty      (empty),
        .full       (full),
        .level      (level),
`ifdef RX_FIFO_ALMOST_FULL_EN
        .almost_full(almost_full),
`endif
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q_m.size();
        check({tag, ".level"}, int'(level), sz);
        check({tag, ".empty"}, int'(empty), (sz == 0) ? 1 : 0);
        check({tag, ".full"}, int'(full), (sz == DEPTH) ? 1 : 0);
        check({tag, ".overflow"}, int'(overflow), int'(ovf_m));
        if (sz > 0) begin
            check({tag, ".dout"}, int'(dout), int'(q_m[0]));
        end
`ifdef RX_FIFO_ALMOST_FULL_EN
        check({tag, ".almost_full"}, int'(almost_full), (sz >= 12) ? 1 : 0);
`endif
    endtask

    // One clock with the given inputs; model applies the FIFO rules.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r,
                         input logic c, input string tag);
        int  sz;
        bit  do_rd;
        bit  do_wr;
        bit  dropped;
        wr_tick = w; din = d; rd = r; ovf_clr = c;
        @(posedge clk);
        sz      = q_m.size();
        do_rd   = r && (sz > 0);
        do_wr   = w && ((sz < DEPTH) || r);
        dropped = w && (sz == DEPTH) && !r;
        if (do_rd) void'(q_m.pop_front());
        if (do_wr) q_m.push_back(d);
        if (dropped)  ovf_m = 1'b1;
        else if (c)   ovf_m = 1'b0;
        #1;
        wr_tick = 1'b0; rd = 1'b0; ovf_clr = 1'b0;
        $display("[%0t] %s wr=%0b din=%02h rd=%0b clr=%0b -> level=%0d dout=%02h ovf=%0b",
                 $time, tag, w, d, r, c, level, dout, overflow);
        check_all(tag);
    endtask

    // Reset with arbitrary concurrent inputs; reset must win.
    task automatic do_reset(input logic w, input logic r, input logic c, input string tag);
        reset = 1'b1; wr_tick = w; din = 8'hEE; rd = r; ovf_clr = c;
        @(posedge clk);
        q_m.delete();
        ovf_m = 1'b0;
        #1;
        reset = 1'b0; wr_tick = 1'b0; rd = 1'b0; ovf_clr = 1'b0;
        $display("[%0t] %s reset -> level=%0d empty=%0b dout=%02h", $time, tag, level, empty, dout);
        check_all(tag);
        check({tag, ".dout0"}, int'(dout), 0);
    endtask

    initial begin
        // Test 1: basic writes and pops
        do_reset(1'b0, 1'b0, 1'b0, "t1_rst");
        cycle(1, 8'h41, 0, 0, "t1_w");
        cycle(0, 8'h00, 0, 0, "t1_idle");
        cycle(1, 8'h42, 0, 0, "t1_w");
        cycle(0, 8'h00, 0, 0, "t1_idle");
        cycle(1, 8'h43, 0, 0, "t1_w");
        check("t1.dout41", int'(dout), 8'h41);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0, "t1_pop");

        // Test 2: fill, overflow, drain
        for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0, "t2_fill");
        cycle(1, 8'hAA, 0, 0, "t2_drop");
        check("t2.ovf", int'(overflow), 1);
        for (int i = 0; i < 16; i++) begin
            check("t2.drain_seq", int'(dout), i);
            cycle(0, 8'h00, 1, 0, "t2_drain");
        end

        // Test 3: simultaneous read+write while full
        do_reset(1'b0, 1'b0, 1'b0, "t3_rst");
        for (int i = 0; i < 16; i++) cycle(1, 8'(8'h10 + i), 0, 0, "t3_fill");
        cycle(1, 8'h55, 1, 0, "t3_rw_full");
        check("t3.ovf0", int'(overflow), 0);
        for (int i = 0; i < 16; i++) cycle(0, 8'h00, 1, 0, "t3_drain");

        // Test 4: simultaneous read+write while empty; read on empty
        cycle(1, 8'h7E, 1, 0, "t4_rw_empty");
        check("t4.dout7e", int'(dout), 8'h7E);
        cycle(0, 8'h00, 1, 0, "t4_pop");
        cycle(0, 8'h00, 1, 0, "t4_rd_empty");

        // Test 5: pointer wrap, overflow clear, clear vs drop
        do_reset(1'b0, 1'b0, 1'b0, "t5_rst");
        for (int i = 0; i < 10; i++) cycle(1, 8'(i), 0, 0, "t5_w");
        for (int i = 0; i < 10; i++) cycle(0, 8'h00, 1, 0, "t5_r");
        for (int i = 0; i < 10; i++) cycle(1, 8'(8'h90 + i), 0, 0, "t5_wrap_w");
        for (int i = 0; i < 10; i++) begin
            check("t5.wrap_seq", int'(dout), 8'h90 + i);
            cycle(0, 8'h00, 1, 0, "t5_wrap_r");
        end
        for (int i = 0; i < 17; i++) cycle(1, 8'(8'hC0 + i), 0, 0, "t5_ovf");
        cycle(0, 8'h00, 0, 1, "t5_clr");
        check("t5.ovf_cleared", int'(overflow), 0);
        cycle(1, 8'hDD, 0, 1, "t5_clr_drop");
        check("t5.ovf_set_wins", int'(overflow), 1);

        // Test 6: reset mid-burst, almost_full threshold
        do_reset(1'b0, 1'b0, 1'b0, "t6_rst0");
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h60 + i), 0, 0, "t6_w");
        do_reset(1'b1, 1'b1, 1'b0, "t6_rst_mid");
        for (int i = 0; i < 12; i++) cycle(1, 8'(8'h70 + i), 0, 0, "t6_af");
        cycle(0, 8'h00, 1, 0, "t6_af_down");

        // Randomized traffic against the model
        do_reset(1'b0, 1'b0, 1'b0, "rnd_rst");
        for (int n = 0; n < 600; n++) begin
            logic w, r, c;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 249) == 0)
                do_reset(w, r, c, "rnd_rst");
            else
                cycle(w, 8'($urandom), r, c, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
